// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, FUNCT3 codes,
// access sizes and the size/sign decode helpers used by the datapath.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_RESP   = 2'd1,
    STORE_MERGE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // 011/110/111 fall through to WORD so unused load encodings behave as LW.
  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = BYTE;
      2'b01:   size_of = HALF;
      default: size_of = WORD;
    endcase
  endfunction

  function automatic logic is_signed(input logic [2:0] funct3);
    is_signed = (funct3 != F3_LBU) && (funct3 != F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane datapath: load extraction with sign/zero extension
// and the read-modify-write merge of a byte or halfword into a RAM word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_lane,
  input  logic [SIZE-1:0] i_q_ram,
  input  logic [SIZE-1:0] i_store_data,
  output logic [SIZE-1:0] o_load_data,
  output logic [SIZE-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;
  lsu_size_e   w_size;

  always_comb begin
    w_size = size_of(i_funct3);
    w_byte = i_q_ram[{i_lane, 3'b000} +: 8];
    w_half = i_q_ram[{i_lane[1], 4'b0000} +: 16];
    w_sign = is_signed(i_funct3);

    o_load_data = i_q_ram;
    o_merged    = i_q_ram;
    case (w_size)
      BYTE: begin
        o_load_data = {{(SIZE-8){w_sign & w_byte[7]}}, w_byte};
        o_merged[{i_lane, 3'b000} +: 8] = i_store_data[7:0];
      end
      HALF: begin
        o_load_data = {{(SIZE-16){w_sign & w_half[15]}}, w_half};
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_store_data[15:0];
      end
      default: begin
        o_load_data = i_q_ram;
        o_merged    = i_store_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: FSM, request latches and RAM port muxing.
// Define LSU_MISALIGN_CHECK_EN to abort misaligned half/word accesses.
//
// state       | meaning
// IDLE        | accept request; SW and misaligned aborts finish here
// LOAD_RESP   | RAM word arrives, extract/extend and complete the load
// STORE_MERGE | RAM word arrives, merge the lane and write it back
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_READ,
  input  logic                  REQ_WRITE,
  input  logic [2:0]            FUNCT3,
  input  logic [ADDR_WIDTH+1:0] BYTE_ADDR,
  input  logic [SIZE-1:0]       STORE_DATA,
  output logic [SIZE-1:0]       LOAD_DATA,
  output logic                  DONE,
  output logic                  STALL,
  output logic                  MISALIGNED,
  output logic [ADDR_WIDTH-1:0] ADDR_RAM,
  input  logic [SIZE-1:0]       Q_RAM,
  output logic [SIZE-1:0]       Q_W,
  output logic                  ENABLE_W
);

  localparam logic [1:0] S_IDLE        = 2'(IDLE);
  localparam logic [1:0] S_LOAD_RESP   = 2'(LOAD_RESP);
  localparam logic [1:0] S_STORE_MERGE = 2'(STORE_MERGE);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;
  logic [SIZE-1:0]       r_data;

  logic [1:0]            w_next;
  logic                  w_req;
  logic                  w_misaligned;
  logic                  w_accept;
  lsu_size_e             w_size;
  logic [ADDR_WIDTH-1:0] w_addr_ram;
  logic [SIZE-1:0]       w_q_w;
  logic [SIZE-1:0]       w_load_data;
  logic [SIZE-1:0]       w_extracted;
  logic [SIZE-1:0]       w_merged;
  logic                  w_we;
  logic                  w_done;
  logic                  w_stall;
  logic                  w_mis_out;

  assign w_req  = REQ_READ | REQ_WRITE;
  assign w_size = size_of(FUNCT3);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misaligned = ((w_size == HALF) && BYTE_ADDR[0]) ||
                        ((w_size == WORD) && (BYTE_ADDR[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  lsu_align #(.SIZE(SIZE)) u_align (
    .i_funct3     (r_funct3),
    .i_lane       (r_lane),
    .i_q_ram      (Q_RAM),
    .i_store_data (r_data),
    .o_load_data  (w_extracted),
    .o_merged     (w_merged)
  );

  always_comb begin
    w_next      = r_state;
    w_addr_ram  = BYTE_ADDR[ADDR_WIDTH+1:2];
    w_q_w       = '0;
    w_load_data = '0;
    w_we        = 1'b0;
    w_done      = 1'b0;
    w_stall     = 1'b0;
    w_mis_out   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_misaligned) begin
            w_done    = 1'b1;
            w_mis_out = 1'b1;
          end else if (REQ_WRITE && (w_size == WORD)) begin
            w_we   = 1'b1;
            w_q_w  = STORE_DATA;
            w_done = 1'b1;
          end else begin
            // Write wins when both requests are raised together.
            w_stall  = 1'b1;
            w_accept = 1'b1;
            w_next   = REQ_WRITE ? S_STORE_MERGE : S_LOAD_RESP;
          end
        end
      end
      S_LOAD_RESP: begin
        w_addr_ram  = r_addr;
        w_load_data = w_extracted;
        w_done      = 1'b1;
        w_next      = S_IDLE;
      end
      S_STORE_MERGE: begin
        w_addr_ram = r_addr;
        w_q_w      = w_merged;
        w_we       = 1'b1;
        w_done     = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_lane   <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= BYTE_ADDR[ADDR_WIDTH+1:2];
        r_funct3 <= FUNCT3;
        r_lane   <= BYTE_ADDR[1:0];
        r_data   <= STORE_DATA;
      end
    end
  end

  // Outputs are gated by reset so nothing, including a pending merge write, leaks out.
  assign LOAD_DATA  = RESET_N ? w_load_data : '0;
  assign Q_W        = RESET_N ? w_q_w : '0;
  assign ADDR_RAM   = RESET_N ? w_addr_ram : '0;
  assign DONE       = RESET_N & w_done;
  assign STALL      = RESET_N & w_stall;
  assign MISALIGNED = RESET_N & w_mis_out;
  assign ENABLE_W   = RESET_N & w_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, hand-written corner
// sequences and random accesses checked against a byte-addressed memory model.
module tb_load_store_unit;

  localparam int AW = 10;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          REQ_READ = 1'b0;
  logic          REQ_WRITE = 1'b0;
  logic [2:0]    FUNCT3 = '0;
  logic [AW+1:0] BYTE_ADDR = '0;
  logic [31:0]   STORE_DATA = '0;
  logic [31:0]   LOAD_DATA;
  logic          DONE, STALL, MISALIGNED, ENABLE_W;
  logic [AW-1:0] ADDR_RAM;
  logic [31:0]   Q_RAM = '0;
  logic [31:0]   Q_W;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_idx = '0;
  logic [31:0]   bd_val = '0;

  logic [31:0] ram   [0:(1<<AW)-1];
  logic [7:0]  mem_b [0:(4<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.SIZE(32), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_READ(REQ_READ), .REQ_WRITE(REQ_WRITE),
    .FUNCT3(FUNCT3), .BYTE_ADDR(BYTE_ADDR), .STORE_DATA(STORE_DATA),
    .LOAD_DATA(LOAD_DATA), .DONE(DONE), .STALL(STALL), .MISALIGNED(MISALIGNED),
    .ADDR_RAM(ADDR_RAM), .Q_RAM(Q_RAM), .Q_W(Q_W), .ENABLE_W(ENABLE_W)
  );

  always @(posedge CLK) begin
    if (bd_we) ram[bd_idx] <= bd_val;
    else if (ENABLE_W) ram[ADDR_RAM] <= Q_W;
    Q_RAM <= ram[ADDR_RAM];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    bd_idx = idx[AW-1:0];
    bd_val = val;
    bd_we  = 1'b1;
    @(posedge CLK); #1;
    bd_we = 1'b0;
    for (int i = 0; i < 4; i++) mem_b[idx*4+i] = val[8*i +: 8];
  endtask

  // Reference model: plain byte memory, access size in bytes, arithmetic extension.
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [11:0] addr);
    return CHECK_EN && ((int'(addr) % nbytes(f3)) != 0);
  endfunction

  function automatic int ref_base(input logic [2:0] f3, input logic [11:0] addr);
    return int'(addr) - (int'(addr) % nbytes(f3));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [11:0] addr);
    longint v = 0;
    int n = nbytes(f3);
    int b = ref_base(f3, addr);
    for (int i = 0; i < n; i++) v += longint'(mem_b[b+i]) << (8*i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] data);
    int n = nbytes(f3);
    int b = ref_base(f3, addr);
    for (int i = 0; i < n; i++) mem_b[b+i] = data[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {mem_b[idx*4+3], mem_b[idx*4+2], mem_b[idx*4+1], mem_b[idx*4]};
  endfunction

  // Called just after a rising edge; returns just after the edge ending the access.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [11:0] addr, input logic [31:0] data,
                        output logic [31:0] ld, output int stalls,
                        output logic mis, output logic got);
    REQ_READ = rd; REQ_WRITE = wr; FUNCT3 = f3; BYTE_ADDR = addr; STORE_DATA = data;
    stalls = 0; got = 1'b0; ld = '0; mis = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (STALL) stalls++;
      if (DONE) begin
        ld = LOAD_DATA; mis = MISALIGNED; got = 1'b1;
      end
      @(posedge CLK); #1;
      if (got) break;
    end
    REQ_READ = 1'b0; REQ_WRITE = 1'b0;
  endtask

  task automatic run_and_check(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] ld;
    int stalls;
    logic mis, got;
    bit exp_mis = ref_mis(f3, addr);
    int exp_stalls = exp_mis ? 0 : ((wr && nbytes(f3) == 4) ? 0 : 1);
    access(rd, wr, f3, addr, data, ld, stalls, mis, got);
    check("rnd_done", 32'(got), 32'd1);
    check("rnd_stalls", 32'(stalls), 32'(exp_stalls));
    check("rnd_misaligned", 32'(mis), 32'(exp_mis));
    if (!wr) begin
      check("rnd_load_data", ld, exp_mis ? 32'd0 : ref_load(f3, addr));
    end else begin
      if (!exp_mis) ref_store(f3, addr, data);
      check("rnd_ram_word", ram[addr[11:2]], ref_word(int'(addr[11:2])));
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp_ld;
    int          exp_stalls;
    logic        exp_mis;
    int          chk_word;
    logic [31:0] exp_word;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [11:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_ld, input int stl, input logic mis,
                              input int wi, input logic [31:0] wv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.data = data;
    v.exp_ld = exp_ld; v.exp_stalls = stl; v.exp_mis = mis;
    v.chk_word = wi; v.exp_word = wv;
    return v;
  endfunction

  vec_t vecs [17];

  initial begin
    logic [31:0] ld;
    int stalls;
    logic mis, got;
    logic [2:0] load_f3s [8];
    load_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    REQ_WRITE = 1'b1; FUNCT3 = 3'b010; BYTE_ADDR = 12'h010; STORE_DATA = 32'hFFFF_FFFF;
    @(negedge CLK);
    check("reset_outputs_zero",
          32'(DONE | STALL | MISALIGNED | ENABLE_W | (|LOAD_DATA) | (|Q_W) | (|ADDR_RAM)), 32'd0);
    REQ_WRITE = 1'b0; BYTE_ADDR = '0; STORE_DATA = '0; FUNCT3 = '0;

    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    set_word(0, 32'h0000_0000);
    set_word(1, 32'h0BAD_F00D);
    set_word(3, 32'h8081_F2A4);
    set_word(4, 32'h1122_3344);
    @(negedge CLK); RESET_N = 1'b1;
    @(negedge CLK);
    check("idle_outputs_zero",
          32'(DONE | STALL | MISALIGNED | ENABLE_W | (|LOAD_DATA) | (|Q_W) | (|ADDR_RAM)), 32'd0);
    @(posedge CLK); #1;

    vecs[0]  = mk(1, 0, 3'b000, 12'h00D, 0, 32'hFFFF_FFF2, 1, 0, -1, 0);
    vecs[1]  = mk(1, 0, 3'b100, 12'h00D, 0, 32'h0000_00F2, 1, 0, -1, 0);
    vecs[2]  = mk(1, 0, 3'b001, 12'h00E, 0, 32'hFFFF_8081, 1, 0, -1, 0);
    vecs[3]  = mk(1, 0, 3'b101, 12'h00E, 0, 32'h0000_8081, 1, 0, -1, 0);
    vecs[4]  = mk(1, 0, 3'b010, 12'h00C, 0, 32'h8081_F2A4, 1, 0, -1, 0);
    vecs[5]  = mk(1, 0, 3'b000, 12'h00C, 0, 32'hFFFF_FFA4, 1, 0, -1, 0);
    vecs[6]  = mk(1, 0, 3'b100, 12'h00F, 0, 32'h0000_0080, 1, 0, -1, 0);
    vecs[7]  = mk(1, 0, 3'b001, 12'h00C, 0, 32'hFFFF_F2A4, 1, 0, -1, 0);
    vecs[8]  = mk(0, 1, 3'b000, 12'h011, 32'h1234_56AB, 0, 1, 0, 4, 32'h1122_AB44);
    vecs[9]  = mk(0, 1, 3'b001, 12'h012, 32'h9999_CDEF, 0, 1, 0, 4, 32'hCDEF_AB44);
    vecs[10] = mk(1, 0, 3'b010, 12'h010, 0, 32'hCDEF_AB44, 1, 0, -1, 0);
    vecs[11] = CHECK_EN ? mk(1, 0, 3'b010, 12'h006, 0, 32'h0, 0, 1, -1, 0)
                        : mk(1, 0, 3'b010, 12'h006, 0, 32'h0BAD_F00D, 1, 0, -1, 0);
    vecs[12] = CHECK_EN ? mk(1, 0, 3'b001, 12'h00D, 0, 32'h0, 0, 1, -1, 0)
                        : mk(1, 0, 3'b001, 12'h00D, 0, 32'hFFFF_F2A4, 1, 0, -1, 0);
    vecs[13] = mk(0, 1, 3'b000, 12'h003, 32'h0000_0077, 0, 1, 0, 0, 32'h7700_0000);
    vecs[14] = mk(1, 0, 3'b111, 12'h00C, 0, 32'h8081_F2A4, 1, 0, -1, 0);
    vecs[15] = CHECK_EN ? mk(0, 1, 3'b010, 12'h011, 32'h5555_AAAA, 0, 0, 1, 4, 32'hCDEF_AB44)
                        : mk(0, 1, 3'b010, 12'h011, 32'h5555_AAAA, 0, 0, 0, 4, 32'h5555_AAAA);
    vecs[16] = mk(1, 1, 3'b010, 12'h008, 32'h0123_4567, 0, 0, 0, 2, 32'h0123_4567);

    for (int i = 0; i < 17; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].data, ld, stalls, mis, got);
      check($sformatf("vec%0d_done", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
      check($sformatf("vec%0d_misaligned", i), 32'(mis), 32'(vecs[i].exp_mis));
      if (!vecs[i].wr) check($sformatf("vec%0d_load_data", i), ld, vecs[i].exp_ld);
      if (vecs[i].chk_word >= 0)
        check($sformatf("vec%0d_ram_word", i), ram[vecs[i].chk_word], vecs[i].exp_word);
      if (vecs[i].wr && !vecs[i].exp_mis) ref_store(vecs[i].f3, vecs[i].addr, vecs[i].data);
    end

    // SW completes in its own cycle with the write on the RAM port.
    REQ_WRITE = 1'b1; FUNCT3 = 3'b010; BYTE_ADDR = 12'h010; STORE_DATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("sw_done", 32'(DONE), 32'd1);
    check("sw_enable_w", 32'(ENABLE_W), 32'd1);
    check("sw_addr_ram", 32'(ADDR_RAM), 32'd4);
    check("sw_q_w", Q_W, 32'hDEAD_BEEF);
    check("sw_stall", 32'(STALL), 32'd0);
    @(posedge CLK); #1;
    REQ_WRITE = 1'b0;
    check("sw_ram_word", ram[4], 32'hDEAD_BEEF);
    ref_store(3'b010, 12'h010, 32'hDEAD_BEEF);

    // Reset asserted while a byte store waits in the merge state.
    set_word(5, 32'h1111_1111);
    REQ_WRITE = 1'b1; FUNCT3 = 3'b000; BYTE_ADDR = 12'h014; STORE_DATA = 32'h0000_00AB;
    @(negedge CLK);
    check("rst_mid_sb_stall", 32'(STALL), 32'd1);
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    check("rst_mid_outputs_zero",
          32'(DONE | STALL | MISALIGNED | ENABLE_W | (|LOAD_DATA) | (|Q_W) | (|ADDR_RAM)), 32'd0);
    @(posedge CLK); #1;
    REQ_WRITE = 1'b0; BYTE_ADDR = '0; STORE_DATA = '0;
    check("rst_mid_ram_unchanged", ram[5], 32'h1111_1111);
    @(negedge CLK); RESET_N = 1'b1;
    @(negedge CLK);
    check("rst_release_outputs_zero",
          32'(DONE | STALL | MISALIGNED | ENABLE_W | (|LOAD_DATA) | (|Q_W) | (|ADDR_RAM)), 32'd0);
    @(posedge CLK); #1;
    check("rst_release_ram_unchanged", ram[5], 32'h1111_1111);
    run_and_check(1'b1, 1'b0, 3'b010, 12'h014, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = 12'($urandom_range(0, 63));
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        run_and_check(1'b1, 1'b0, load_f3s[$urandom_range(0, 7)], a, d);
      else
        run_and_check(($urandom_range(0, 7) == 0), 1'b1, 3'($urandom_range(0, 2)), a, d);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
